// File: rtl/rvlab_dmi_jtag_reg.sv
// JTAG DMI access register: shifts {addr, data, op} through TDI/TDO and turns
// updates into DMI request/response handshakes with a sticky dmistat error.
module rvlab_dmi_jtag_reg #(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 td_i,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_reset_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [DataWidth-1:0] dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [DataWidth-1:0] dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned SrWidth = AddrWidth + DataWidth + 2;

    typedef enum logic [2:0] {Idle, Read, WaitRead, Write, WaitWrite} state_e;

    state_e                 state_q;
    logic [SrWidth-1:0]     sr_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   data_q;
    logic [1:0]             error_q;

    logic [AddrWidth-1:0]   sr_addr;
    logic [DataWidth-1:0]   sr_data;
    logic [1:0]             sr_op;
    logic                   busy_err;
    logic                   fail_err;
    logic [1:0]             cop;

    assign sr_addr = sr_q[SrWidth-1 -: AddrWidth];
    assign sr_data = sr_q[DataWidth+1 -: DataWidth];
    assign sr_op   = sr_q[1:0];

    // Busy (3) outranks failed (2) when both are raised in the same cycle.
    function automatic logic [1:0] next_error(input logic [1:0] cur, input logic clr,
                                              input logic busy, input logic fail);
        logic [1:0] raised;
        raised = busy ? 2'd3 : (fail ? 2'd2 : 2'd0);
        if (clr)           return raised;
        else if (cur == 0) return raised;
        else               return cur;
    endfunction

    assign busy_err = dmi_access_i && (update_dr_i || capture_dr_i) && (state_q != Idle);
    assign fail_err = dmi_resp_valid_i && dmi_resp_ready_o && (dmi_resp_resp_i != 2'd0);
    assign cop      = (state_q != Idle) ? 2'd3 : error_q;

    assign dmi_tdo_o        = sr_q[0];
    assign dmi_error_o      = error_q;
    assign dmi_req_valid_o  = (state_q == Read) || (state_q == Write);
    assign dmi_resp_ready_o = (state_q == WaitRead) || (state_q == WaitWrite);
    assign dmi_req_op_o     = (state_q == Read) ? 2'd1 : ((state_q == Write) ? 2'd2 : 2'd0);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;

    always_ff @(posedge tck_i) begin
        if (!trst_ni) begin
            state_q <= Idle;
            sr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= 2'd0;
        end else begin
            error_q <= next_error(error_q, dmi_reset_i, busy_err, fail_err);

            // Test-Logic-Reset only clears the scan path; the handshake runs on.
            if (test_logic_reset_i) begin
                sr_q <= '0;
            end else if (dmi_access_i && capture_dr_i) begin
                sr_q <= {addr_q, data_q, cop};
            end else if (dmi_access_i && shift_dr_i) begin
                sr_q <= {td_i, sr_q[SrWidth-1:1]};
            end

            unique case (state_q)
                Idle: begin
                    if (dmi_access_i && update_dr_i && error_q == 2'd0) begin
                        addr_q <= sr_addr;
                        if (sr_op == 2'd1) begin
                            state_q <= Read;
                        end else if (sr_op == 2'd2) begin
                            data_q  <= sr_data;
                            state_q <= Write;
                        end
                    end
                end
                Read:  if (dmi_req_ready_i) state_q <= WaitRead;
                Write: if (dmi_req_ready_i) state_q <= WaitWrite;
                WaitRead: begin
                    if (dmi_resp_valid_i) begin
                        data_q  <= dmi_resp_data_i;
                        state_q <= Idle;
                    end
                end
                WaitWrite: if (dmi_resp_valid_i) state_q <= Idle;
                default: state_q <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_rvlab_dmi_jtag_reg.sv
// Directed bench for rvlab_dmi_jtag_reg: scans DR vectors and drives the DMI
// handshake, comparing against hand-computed values.
module tb_rvlab_dmi_jtag_reg;

    logic        tck = 1'b0;
    logic        trst_n, td, dmi_access, capture_dr, shift_dr, update_dr;
    logic        test_logic_reset, dmi_reset;
    logic        dmi_tdo;
    logic [1:0]  dmi_error;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_resp;

    int checks = 0;
    int failures = 0;

    int          req_cnt = 0;
    logic [6:0]  last_addr;
    logic [31:0] last_data;
    logic [1:0]  last_op;
    logic [40:0] dout;

    always #5 tck = ~tck;

    rvlab_dmi_jtag_reg #(.AddrWidth(7), .DataWidth(32)) dut (
        .tck_i              (tck),
        .trst_ni            (trst_n),
        .td_i               (td),
        .dmi_access_i       (dmi_access),
        .capture_dr_i       (capture_dr),
        .shift_dr_i         (shift_dr),
        .update_dr_i        (update_dr),
        .test_logic_reset_i (test_logic_reset),
        .dmi_reset_i        (dmi_reset),
        .dmi_tdo_o          (dmi_tdo),
        .dmi_error_o        (dmi_error),
        .dmi_req_valid_o    (req_valid),
        .dmi_req_ready_i    (req_ready),
        .dmi_req_addr_o     (req_addr),
        .dmi_req_data_o     (req_data),
        .dmi_req_op_o       (req_op),
        .dmi_resp_valid_i   (resp_valid),
        .dmi_resp_ready_o   (resp_ready),
        .dmi_resp_data_i    (resp_data),
        .dmi_resp_resp_i    (resp_resp)
    );

    // Record every accepted request.
    always @(posedge tck) begin
        if (trst_n && req_valid && req_ready) begin
            req_cnt   <= req_cnt + 1;
            last_addr <= req_addr;
            last_data <= req_data;
            last_op   <= req_op;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge tck);
    endtask

    // Capture, shift 41 bits LSB first (recording TDO), then update.
    task automatic dr_scan(input logic [40:0] din, output logic [40:0] so);
        so = '0;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        for (int i = 0; i < 41; i++) begin
            td       = din[i];
            shift_dr = 1'b1;
            so[i]    = dmi_tdo;
            tick();
        end
        shift_dr  = 1'b0;
        td        = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic pulse_ready();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic pulse_resp(input logic [31:0] d, input logic [1:0] r);
        resp_valid = 1'b1;
        resp_data  = d;
        resp_resp  = r;
        tick();
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_resp  = 2'd0;
    endtask

    initial begin
        trst_n = 1'b0; td = 1'b0; dmi_access = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0;
        update_dr = 1'b0; test_logic_reset = 1'b0; dmi_reset = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_resp = 2'd0;
        tick(); tick();
        check("rst_tdo", dmi_tdo, 0);
        check("rst_err", dmi_error, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_resp_ready", resp_ready, 0);
        check("rst_op", req_op, 0);
        trst_n = 1'b1;
        tick();

        // Write 0xDEADBEEF to 0x10, ready after 3 cycles.
        dr_scan({7'h10, 32'hDEADBEEF, 2'd2}, dout);
        check("wr_first_capture", dout, 0);
        check("wr_valid", req_valid, 1);
        check("wr_resp_ready_low", resp_ready, 0);
        check("wr_addr", req_addr, 7'h10);
        check("wr_data", req_data, 32'hDEADBEEF);
        check("wr_op", req_op, 2);
        tick(); tick(); tick();
        check("wr_valid_held", req_valid, 1);
        pulse_ready();
        check("wr_valid_drop", req_valid, 0);
        check("wr_wait_resp_ready", resp_ready, 1);
        pulse_resp(32'h0, 2'd0);
        check("wr_done_resp_ready", resp_ready, 0);
        check("wr_err", dmi_error, 0);
        check("wr_req_cnt", req_cnt, 1);
        check("wr_req_log", {last_addr, last_data, last_op}, {7'h10, 32'hDEADBEEF, 2'd2});

        // Read 0x11; capture shows previous write state.
        dr_scan({7'h11, 32'h0, 2'd1}, dout);
        check("rd_capture_prev", dout, {7'h10, 32'hDEADBEEF, 2'd0});
        check("rd_valid", req_valid, 1);
        check("rd_op", req_op, 1);
        check("rd_addr", req_addr, 7'h11);
        pulse_ready();
        pulse_resp(32'h12345678, 2'd0);
        dr_scan(41'h0, dout);
        check("rd_shift_out", dout, {7'h11, 32'h12345678, 2'd0});
        check("rd_req_cnt", req_cnt, 2);

        // Busy: capture while Read pending.
        dr_scan({7'h05, 32'h0, 2'd1}, dout);
        check("busy_valid", req_valid, 1);
        dr_scan({7'h06, 32'h0000AAAA, 2'd2}, dout);
        check("busy_cop", dout[1:0], 3);
        check("busy_err", dmi_error, 3);
        check("busy_addr_kept", req_addr, 7'h05);
        check("busy_op_kept", req_op, 1);
        pulse_ready();
        pulse_resp(32'h0BADF00D, 2'd0);
        check("busy_err_sticky", dmi_error, 3);
        check("busy_req_cnt", req_cnt, 3);
        dr_scan({7'h07, 32'h0, 2'd1}, dout);
        check("busy_idle_cop", dout[1:0], 3);
        check("busy_update_ignored", req_valid, 0);
        check("busy_addr_unlatched", req_addr, 7'h05);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        check("busy_cleared", dmi_error, 0);

        // New read accepted, fails with resp=2.
        dr_scan({7'h08, 32'h0, 2'd1}, dout);
        check("fail_read_accepted", req_valid, 1);
        check("fail_addr", req_addr, 7'h08);
        pulse_ready();
        pulse_resp(32'hFFFF0000, 2'd2);
        check("fail_err", dmi_error, 2);
        dr_scan({7'h09, 32'h0, 2'd1}, dout);
        check("fail_cop", dout[1:0], 2);
        check("fail_update_ignored", req_valid, 0);
        check("fail_addr_kept", req_addr, 7'h08);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        check("fail_cleared", dmi_error, 0);

        // Busy raised in the same cycle as dmi_reset wins.
        dr_scan({7'h0C, 32'h0, 2'd1}, dout);
        capture_dr = 1'b1;
        dmi_reset  = 1'b1;
        tick();
        capture_dr = 1'b0;
        dmi_reset  = 1'b0;
        check("same_cycle_err_wins", dmi_error, 3);
        dmi_reset = 1'b1;
        tick();
        dmi_reset = 1'b0;
        check("same_cycle_then_clear", dmi_error, 0);
        pulse_ready();
        pulse_resp(32'h0, 2'd0);
        check("same_cycle_req_cnt", req_cnt, 5);

        // Test-Logic-Reset clears sr only.
        dr_scan({7'h0A, 32'h55AA55AA, 2'd2}, dout);
        for (int i = 0; i < 41; i++) begin
            td       = 1'b1;
            shift_dr = 1'b1;
            tick();
        end
        shift_dr = 1'b0;
        td       = 1'b0;
        check("tlr_pre_tdo", dmi_tdo, 1);
        test_logic_reset = 1'b1;
        tick();
        test_logic_reset = 1'b0;
        check("tlr_tdo", dmi_tdo, 0);
        check("tlr_valid_kept", req_valid, 1);
        check("tlr_addr_kept", req_addr, 7'h0A);
        check("tlr_err_kept", dmi_error, 0);

        // Reset during WaitWrite aborts.
        pulse_ready();
        check("mid_wait_write", resp_ready, 1);
        trst_n = 1'b0;
        tick();
        check("mid_rst_valid", req_valid, 0);
        check("mid_rst_resp_ready", resp_ready, 0);
        check("mid_rst_tdo", dmi_tdo, 0);
        check("mid_rst_op", req_op, 0);
        trst_n = 1'b1;
        tick();

        // Strobes ignored without dmi_access.
        dmi_access = 1'b0;
        for (int i = 0; i < 4; i++) begin
            td       = 1'b1;
            shift_dr = 1'b1;
            tick();
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
        check("noaccess_tdo", dmi_tdo, 0);
        check("noaccess_valid", req_valid, 0);
        check("noaccess_err", dmi_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
